// File: rtl/kpd_pkg.sv
// kpd_pkg: shared states, column strobes and key map for the keypad scanner
package kpd_pkg;
   typedef enum logic [2:0] {SCAN, DEBOUNCE, PRESS, WAIT_REL, REL_DB} state_t;
   localparam logic [3:0] COL_STROBE [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;
   // indexed [row][col], row 0 = top, col 0 = left
   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{KEY_STAR, 4'h0, KEY_HASH, 4'hD}
   };
endpackage

// File: rtl/kpd_decode.sv
// kpd_decode: active-low row pattern plus column index -> key code, top row wins
module kpd_decode
   import kpd_pkg::*;
(
   input  logic [3:0] rows,
   input  logic [1:0] col,
   output logic [3:0] code
);
   logic [1:0] row;
   always_comb begin
      row  = !rows[3] ? 2'd0 : !rows[2] ? 2'd1 : !rows[1] ? 2'd2 : 2'd3;
      code = KEY_MAP[row][col];
   end
endmodule

// File: rtl/kpd_scan_ctrl.sv
// kpd_scan_ctrl: 4x4 keypad column scanner with press/release debounce
// and a valid/ready key output that flags keys dropped while one is pending.
module kpd_scan_ctrl
   import kpd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int SCAN_DIV        = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] kpr,
   output logic [3:0] kpc,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_down,
   output logic       overrun
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   state_t        state;
   logic [3:0]    s1, rs, ref_rows, code;
   logic [1:0]    col;
   logic [CW-1:0] cnt;
   logic [DW-1:0] div;
   logic          accept;
   kpd_decode u_decode (.rows(ref_rows), .col(col), .code(code));
   assign accept = key_valid && key_ready;
   assign kpc    = COL_STROBE[col];
   // cnt stops at CNT_LAST because reaching it always leaves the counting state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1        <= 4'hF;
         rs        <= 4'hF;
         ref_rows  <= 4'hF;
         state     <= SCAN;
         col       <= '0;
         cnt       <= '0;
         div       <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_down  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         s1      <= kpr;
         rs      <= s1;
         overrun <= 1'b0;
         if (accept) key_valid <= 1'b0;
         case (state)
            SCAN:
               if (rs != 4'hF) begin
                  ref_rows <= rs;
                  cnt      <= '0;
                  state    <= DEBOUNCE;
               end else if (div == DIV_LAST) begin
                  div <= '0;
                  col <= col + 2'd1;
               end else div <= div + 1'b1;
            DEBOUNCE:
               if (rs != ref_rows) begin
                  div   <= '0;
                  state <= SCAN;
               end else if (cnt == CNT_LAST) state <= PRESS;
               else cnt <= cnt + 1'b1;
            PRESS: begin
               key_down <= 1'b1;
               state    <= WAIT_REL;
               if (!key_valid || accept) begin
                  key_code  <= code;
                  key_valid <= 1'b1;
               end else overrun <= 1'b1;
            end
            WAIT_REL:
               if (rs == 4'hF) begin
                  cnt   <= '0;
                  state <= REL_DB;
               end
            REL_DB:
               if (rs != 4'hF) state <= WAIT_REL;
               else if (cnt == CNT_LAST) begin
                  key_down <= 1'b0;
                  col      <= col + 2'd1;
                  div      <= '0;
                  state    <= SCAN;
               end else cnt <= cnt + 1'b1;
            default: state <= SCAN;
         endcase
      end
   end
endmodule
